axi_wstrb_seq: RTL and testbench



---
 rtl/axi_pkg.sv | 28 ++
 rtl/axi_lane_mask.sv | 26 ++
 rtl/axi_wstrb_seq.sv | 169 ++++++++++++++++
 tb/tb_axi_wstrb_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, sequencer states, lane-width helper.
package axi_pkg;

    localparam int unsigned SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } seq_state_t;

    // Width of a byte-lane offset for NB lanes (at least one bit).
    function automatic int unsigned lane_off_w(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // log2 of the lane count, i.e. the largest legal transfer size.
    function automatic int unsigned lane_log2(input int unsigned nb);
        return (nb > 1) ? $clog2(nb) : 0;
    endfunction

endpackage

// File: rtl/axi_lane_mask.sv
// Byte-lane strobe for one beat: lanes from the start offset up to the end of
// the size-aligned container that holds it.
module axi_lane_mask
    import axi_pkg::*;
#(
    parameter int unsigned NB = 8
) (
    input  logic [lane_off_w(NB)-1:0] lane_off_i,
    input  logic [SIZE_W-1:0]         size_i,
    output logic [NB-1:0]             strb_o
);

    int unsigned lo_u;
    int unsigned hi_u;

    // Enable lanes lo..hi where hi closes the size-aligned container.
    always_comb begin
        lo_u   = 32'(lane_off_i);
        hi_u   = (lo_u & ~((32'd1 << size_i) - 32'd1)) + (32'd1 << size_i) - 32'd1;
        strb_o = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            strb_o[i] = (i >= lo_u) && (i <= hi_u);
        end
    end

endmodule

// File: rtl/axi_wstrb_seq.sv
// AXI write-strobe sequencer: accepts one AW descriptor and walks its beats,
// presenting registered strobe, address and last flag per beat.
module axi_wstrb_seq
    import axi_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 aw_valid,
    output logic                 aw_ready,
    input  logic [ADDR_W-1:0]    aw_addr,
    input  logic [SIZE_W-1:0]    aw_size,
    input  logic [LEN_W-1:0]     aw_len,
    input  logic [1:0]           aw_burst,
    output logic                 beat_valid,
    input  logic                 beat_ready,
    output logic [DATA_W/8-1:0]  beat_strb,
    output logic [ADDR_W-1:0]    beat_addr,
    output logic                 beat_last,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned NB      = DATA_W / 8;
    localparam int unsigned OFF_W   = lane_off_w(NB);
    localparam int unsigned NB_LOG2 = lane_log2(NB);

    seq_state_t          state_q;
    burst_t              burst_q;
    logic [SIZE_W-1:0]   size_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [NB-1:0]       strb_q;
    logic                valid_q;
    logic                last_q;
    logic                aw_ready_q;
    logic                busy_q;
    logic                err_q;

    burst_t              aw_burst_t;
    logic [ADDR_W-1:0]   aw_step;
    logic                aw_len_ok;
    logic                aw_illegal;
    logic [ADDR_W-1:0]   step;
    logic [ADDR_W-1:0]   wrap_m;
    logic [2:0]          wrap_lg;
    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   mask_addr;
    logic [SIZE_W-1:0]   mask_size;
    logic [OFF_W-1:0]    mask_off;
    logic [NB-1:0]       mask_strb;

    // Descriptor legality check for the incoming AW request.
    always_comb begin
        aw_burst_t = burst_t'(aw_burst);
        aw_step    = ADDR_W'(1) << aw_size;
        aw_len_ok  = (aw_len == LEN_W'(1)) || (aw_len == LEN_W'(3)) ||
                     (aw_len == LEN_W'(7)) || (aw_len == LEN_W'(15));
        aw_illegal = (aw_size > SIZE_W'(NB_LOG2)) || (aw_burst_t == BURST_RSVD) ||
                     ((aw_burst_t == BURST_WRAP) &&
                      (!aw_len_ok || ((aw_addr & (aw_step - ADDR_W'(1))) != '0)));
    end

    // Next beat address; WRAP uses base | ((addr + step) mod total) since base is total-aligned.
    always_comb begin
        step    = ADDR_W'(1) << size_q;
        wrap_lg = 3'd0;
        case (len_q)
            LEN_W'(1):  wrap_lg = 3'd1;
            LEN_W'(3):  wrap_lg = 3'd2;
            LEN_W'(7):  wrap_lg = 3'd3;
            LEN_W'(15): wrap_lg = 3'd4;
            default:    wrap_lg = 3'd0;
        endcase
        wrap_m = (step << wrap_lg) - ADDR_W'(1);
        case (burst_q)
            BURST_FIXED: addr_d = addr_q;
            BURST_WRAP:  addr_d = (addr_q & ~wrap_m) | ((addr_q + step) & wrap_m);
            default:     addr_d = (addr_q & ~(step - ADDR_W'(1))) + step;
        endcase
    end

    // One mask instance serves the first beat (from AW) and later beats (from addr_d).
    always_comb begin
        mask_addr = (state_q == ST_IDLE) ? aw_addr : addr_d;
        mask_size = (state_q == ST_IDLE) ? aw_size : size_q;
        mask_off  = OFF_W'(mask_addr & ADDR_W'(NB - 1));
    end

    axi_lane_mask #(
        .NB (NB)
    ) u_lane_mask (
        .lane_off_i (mask_off),
        .size_i     (mask_size),
        .strb_o     (mask_strb)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            burst_q    <= BURST_FIXED;
            size_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            strb_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            aw_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (aw_valid && aw_ready_q) begin
                        if (aw_illegal) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= ST_BURST;
                            burst_q    <= aw_burst_t;
                            size_q     <= aw_size;
                            len_q      <= aw_len;
                            cnt_q      <= '0;
                            addr_q     <= aw_addr;
                            strb_q     <= mask_strb;
                            valid_q    <= 1'b1;
                            last_q     <= (aw_len == '0);
                            aw_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (valid_q && beat_ready) begin
                        if (last_q) begin
                            state_q    <= ST_IDLE;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                            strb_q     <= '0;
                            aw_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            addr_q <= addr_d;
                            strb_q <= mask_strb;
                            cnt_q  <= cnt_q + LEN_W'(1);
                            last_q <= ((cnt_q + LEN_W'(1)) == len_q);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign aw_ready   = aw_ready_q;
    assign beat_valid = valid_q;
    assign beat_strb  = strb_q;
    assign beat_addr  = addr_q;
    assign beat_last  = last_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_axi_wstrb_seq.sv
// Directed bench for axi_wstrb_seq with DATA_W=64 (8 byte lanes).
module tb_axi_wstrb_seq;

    logic        clk;
    logic        rst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        beat_valid;
    logic        beat_ready;
    logic [7:0]  beat_strb;
    logic [31:0] beat_addr;
    logic        beat_last;
    logic        busy;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;

    axi_wstrb_seq #(
        .DATA_W (64),
        .ADDR_W (32),
        .LEN_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .aw_size    (aw_size),
        .aw_len     (aw_len),
        .aw_burst   (aw_burst),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_strb  (beat_strb),
        .beat_addr  (beat_addr),
        .beat_last  (beat_last),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one descriptor; returns #1 after the accepting edge.
    task automatic send_aw(input logic [31:0] a, input logic [2:0] s,
                           input logic [7:0] l, input logic [1:0] b);
        chk("aw_ready_pre", 64'(aw_ready), 64'd1);
        aw_valid = 1'b1;
        aw_addr  = a;
        aw_size  = s;
        aw_len   = l;
        aw_burst = b;
        @(posedge clk);
        #1;
        aw_valid = 1'b0;
    endtask

    // Check the presented beat, then let it be consumed (beat_ready assumed high).
    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [7:0] s, input logic l);
        chk({tag, "_valid"}, 64'(beat_valid), 64'd1);
        chk({tag, "_addr"},  64'(beat_addr),  64'(a));
        chk({tag, "_strb"},  64'(beat_strb),  64'(s));
        chk({tag, "_last"},  64'(beat_last),  64'(l));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(beat_valid), 64'd0);
        chk({tag, "_awrdy"}, 64'(aw_ready),   64'd1);
        chk({tag, "_busy"},  64'(busy),       64'd0);
        chk({tag, "_err"},   64'(err),        64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_awrdy"}, 64'(aw_ready),   64'd1);
        chk({tag, "_valid"}, 64'(beat_valid), 64'd0);
        chk({tag, "_strb"},  64'(beat_strb),  64'd0);
        chk({tag, "_addr"},  64'(beat_addr),  64'd0);
        chk({tag, "_last"},  64'(beat_last),  64'd0);
        chk({tag, "_busy"},  64'(busy),       64'd0);
        chk({tag, "_err"},   64'(err),        64'd0);
    endtask

    task automatic illegal(input string tag, input logic [31:0] a, input logic [2:0] s,
                           input logic [7:0] l, input logic [1:0] b);
        send_aw(a, s, l, b);
        chk({tag, "_err"},   64'(err),        64'd1);
        chk({tag, "_valid"}, 64'(beat_valid), 64'd0);
        chk({tag, "_awrdy"}, 64'(aw_ready),   64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_err1"},  64'(err),        64'd0);
        chk({tag, "_busy"},  64'(busy),       64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        aw_valid   = 1'b0;
        aw_addr    = '0;
        aw_size    = '0;
        aw_len     = '0;
        aw_burst   = '0;
        beat_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // INCR unaligned, halfword beats
        send_aw(32'h3, 3'd1, 8'd2, 2'd1);
        chk("incr_busy", 64'(busy), 64'd1);
        chk("incr_awrdy", 64'(aw_ready), 64'd0);
        beat("incr0", 32'h3, 8'h08, 1'b0);
        beat("incr1", 32'h4, 8'h30, 1'b0);
        beat("incr2", 32'h6, 8'hC0, 1'b1);
        chk_idle("incr_end");

        // WRAP 4 x 4 bytes from 0x0C
        send_aw(32'h0C, 3'd2, 8'd3, 2'd2);
        beat("wrap0", 32'h0C, 8'hF0, 1'b0);
        beat("wrap1", 32'h00, 8'h0F, 1'b0);
        beat("wrap2", 32'h04, 8'hF0, 1'b0);
        beat("wrap3", 32'h08, 8'h0F, 1'b1);
        chk_idle("wrap_end");

        // FIXED byte beats
        send_aw(32'h5, 3'd0, 8'd3, 2'd0);
        beat("fix0", 32'h5, 8'h20, 1'b0);
        beat("fix1", 32'h5, 8'h20, 1'b0);
        beat("fix2", 32'h5, 8'h20, 1'b0);
        beat("fix3", 32'h5, 8'h20, 1'b1);
        chk_idle("fix_end");

        // Single-beat burst
        send_aw(32'h7, 3'd0, 8'd0, 2'd1);
        beat("len0", 32'h7, 8'h80, 1'b1);
        chk_idle("len0_end");

        // Unaligned full-width INCR: partial first beat
        send_aw(32'h25, 3'd3, 8'd1, 2'd1);
        beat("ua0", 32'h25, 8'hE0, 1'b0);
        beat("ua1", 32'h28, 8'hFF, 1'b1);

        // Illegal descriptors
        illegal("ill_size", 32'h0, 3'd4, 8'd0, 2'd1);
        illegal("ill_wlen", 32'h0, 3'd2, 8'd2, 2'd2);
        illegal("ill_walign", 32'h2, 3'd2, 8'd3, 2'd2);
        illegal("ill_rsvd", 32'h0, 3'd0, 8'd0, 2'd3);

        // Backpressure on beat 0
        beat_ready = 1'b0;
        send_aw(32'h0, 3'd3, 8'd1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 64'(beat_valid), 64'd1);
            chk("bp_addr",  64'(beat_addr),  64'd0);
            chk("bp_strb",  64'(beat_strb),  64'hFF);
            chk("bp_last",  64'(beat_last),  64'd0);
            @(posedge clk);
            #1;
        end
        beat_ready = 1'b1;
        beat("bp0", 32'h0, 8'hFF, 1'b0);
        beat("bp1", 32'h8, 8'hFF, 1'b1);
        chk_idle("bp_end");

        // Reset during beat 2 of an 8-beat INCR
        send_aw(32'h100, 3'd3, 8'd7, 2'd1);
        beat("rb0", 32'h100, 8'hFF, 1'b0);
        beat("rb1", 32'h108, 8'hFF, 1'b0);
        chk("rb2_addr", 64'(beat_addr), 64'h110);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_vals("rst_after");

        // Fresh burst after reset
        send_aw(32'h10, 3'd2, 8'd1, 2'd1);
        beat("post0", 32'h10, 8'h0F, 1'b0);
        beat("post1", 32'h14, 8'hF0, 1'b1);
        chk_idle("post_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
